// File: rtl/ray_pkg.sv
// Shared state encoding and datapath widths for the ray/sphere intersection unit.
package ray_pkg;

    localparam int A_W    = 26;
    localparam int B_W    = 27;
    localparam int C_W    = 28;
    localparam int DISC_W = 56;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DOT    = 3'd1,
        DISC   = 3'd2,
        DECIDE = 3'd3,
        OUT    = 3'd4
    } state_t;

endpackage

// File: rtl/ray_sphere_hit_dot3.sv
// Combinational signed 3-term dot product; operands are sign-extended to the
// result width before multiplying so no partial product is truncated early.
module dot3 #(
    parameter int AW = 12,
    parameter int BW = 12,
    parameter int OW = 26
) (
    input  logic signed [AW-1:0] ax,
    input  logic signed [AW-1:0] ay,
    input  logic signed [AW-1:0] az,
    input  logic signed [BW-1:0] bx,
    input  logic signed [BW-1:0] by,
    input  logic signed [BW-1:0] bz,
    output logic signed [OW-1:0] dot
);

    logic signed [OW-1:0] px_s;
    logic signed [OW-1:0] py_s;
    logic signed [OW-1:0] pz_s;

    assign px_s = OW'(ax) * OW'(bx);
    assign py_s = OW'(ay) * OW'(by);
    assign pz_s = OW'(az) * OW'(bz);
    assign dot  = px_s + py_s + pz_s;

endmodule

// File: rtl/ray_sphere_hit.sv
// Multi-cycle ray/sphere hit test: IDLE -> DOT -> DISC -> DECIDE -> OUT.
// Optional per-frame hit counter enabled by macro RAY_HIT_STATS_EN.
module ray_sphere_hit
    import ray_pkg::*;
#(
    parameter int         COORD_W    = 12,
    parameter int         NUM_PIXELS = 65536,
    parameter logic [7:0] HIT_SHADE  = 8'hFF,
    parameter logic [7:0] BG_SHADE   = 8'h00
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [COORD_W-1:0] ray_dir_x,
    input  logic signed [COORD_W-1:0] ray_dir_y,
    input  logic signed [COORD_W-1:0] ray_dir_z,
    input  logic [31:0]               pixel_index,
    input  logic signed [COORD_W-1:0] camera_pos_x,
    input  logic signed [COORD_W-1:0] camera_pos_y,
    input  logic signed [COORD_W-1:0] camera_pos_z,
    input  logic signed [COORD_W-1:0] sphere_cx,
    input  logic signed [COORD_W-1:0] sphere_cy,
    input  logic signed [COORD_W-1:0] sphere_cz,
    input  logic [COORD_W-1:0]        sphere_r,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      hit,
    output logic [7:0]                shade,
    output logic [31:0]               pixel_index_out,
    output logic                      last
`ifdef RAY_HIT_STATS_EN
    ,
    output logic [31:0]               hit_count
`endif
);

    localparam int OC_W = COORD_W + 1;

    state_t                      state_r;
    logic signed [COORD_W-1:0]   dir_x_r, dir_y_r, dir_z_r;
    logic signed [COORD_W-1:0]   org_x_r, org_y_r, org_z_r;
    logic signed [COORD_W-1:0]   cen_x_r, cen_y_r, cen_z_r;
    logic [COORD_W-1:0]          rad_r;
    logic [31:0]                 tag_r;
    logic signed [A_W-1:0]       a_r;
    logic signed [B_W-1:0]       b_r;
    logic signed [C_W-1:0]       c_r;
    logic signed [DISC_W-1:0]    disc_r;

    logic signed [OC_W-1:0]      oc_x_s, oc_y_s, oc_z_s;
    logic signed [A_W-1:0]       a_s;
    logic signed [B_W-1:0]       b_s;
    logic signed [C_W-1:0]       occ_s;
    logic [C_W-1:0]              r_sq_s;
    logic signed [C_W-1:0]       c_s;
    logic signed [DISC_W-1:0]    disc_s;
    logic                        zero_dir_s;
    logic                        hit_s;
    logic                        accept_s;
    logic                        done_s;

    assign oc_x_s = OC_W'(org_x_r) - OC_W'(cen_x_r);
    assign oc_y_s = OC_W'(org_y_r) - OC_W'(cen_y_r);
    assign oc_z_s = OC_W'(org_z_r) - OC_W'(cen_z_r);

    dot3 #(.AW(COORD_W), .BW(COORD_W), .OW(A_W)) u_dot_dd (
        .ax(dir_x_r), .ay(dir_y_r), .az(dir_z_r),
        .bx(dir_x_r), .by(dir_y_r), .bz(dir_z_r),
        .dot(a_s)
    );

    dot3 #(.AW(OC_W), .BW(COORD_W), .OW(B_W)) u_dot_od (
        .ax(oc_x_s), .ay(oc_y_s), .az(oc_z_s),
        .bx(dir_x_r), .by(dir_y_r), .bz(dir_z_r),
        .dot(b_s)
    );

    dot3 #(.AW(OC_W), .BW(OC_W), .OW(C_W)) u_dot_oo (
        .ax(oc_x_s), .ay(oc_y_s), .az(oc_z_s),
        .bx(oc_x_s), .by(oc_y_s), .bz(oc_z_s),
        .dot(occ_s)
    );

    // Radius is unsigned, so zero-extend before squaring.
    assign r_sq_s = C_W'(rad_r) * C_W'(rad_r);
    assign c_s    = occ_s - $signed(r_sq_s);
    assign disc_s = DISC_W'(b_r) * DISC_W'(b_r) - DISC_W'(a_r) * DISC_W'(c_r);

    assign zero_dir_s = (dir_x_r == {COORD_W{1'b0}}) && (dir_y_r == {COORD_W{1'b0}})
                     && (dir_z_r == {COORD_W{1'b0}});
    // Hit needs a real root in front of the camera; a null direction never hits.
    assign hit_s    = !zero_dir_s && !disc_r[DISC_W-1] && b_r[B_W-1];
    assign in_ready = (state_r == IDLE) && en;
    assign accept_s = in_valid && in_ready;
    assign done_s   = out_valid && out_ready;

    // Sequencer, capture registers, datapath stages and registered results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= IDLE;
            dir_x_r         <= '0;
            dir_y_r         <= '0;
            dir_z_r         <= '0;
            org_x_r         <= '0;
            org_y_r         <= '0;
            org_z_r         <= '0;
            cen_x_r         <= '0;
            cen_y_r         <= '0;
            cen_z_r         <= '0;
            rad_r           <= '0;
            tag_r           <= 32'd0;
            a_r             <= '0;
            b_r             <= '0;
            c_r             <= '0;
            disc_r          <= '0;
            out_valid       <= 1'b0;
            hit             <= 1'b0;
            shade           <= 8'd0;
            pixel_index_out <= 32'd0;
            last            <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        dir_x_r <= ray_dir_x;
                        dir_y_r <= ray_dir_y;
                        dir_z_r <= ray_dir_z;
                        org_x_r <= camera_pos_x;
                        org_y_r <= camera_pos_y;
                        org_z_r <= camera_pos_z;
                        cen_x_r <= sphere_cx;
                        cen_y_r <= sphere_cy;
                        cen_z_r <= sphere_cz;
                        rad_r   <= sphere_r;
                        tag_r   <= pixel_index;
                        state_r <= DOT;
                    end
                end
                DOT: begin
                    a_r     <= a_s;
                    b_r     <= b_s;
                    c_r     <= c_s;
                    state_r <= DISC;
                end
                DISC: begin
                    disc_r  <= disc_s;
                    state_r <= DECIDE;
                end
                DECIDE: begin
                    hit             <= hit_s;
                    shade           <= hit_s ? HIT_SHADE : BG_SHADE;
                    last            <= (tag_r == 32'(NUM_PIXELS - 1));
                    pixel_index_out <= tag_r;
                    out_valid       <= 1'b1;
                    state_r         <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

`ifdef RAY_HIT_STATS_EN
    logic clr_pend_r;

    // Frame hit counter; clears the cycle after the frame's last result leaves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= 32'd0;
            clr_pend_r <= 1'b0;
        end else if (clr_pend_r) begin
            hit_count  <= 32'd0;
            clr_pend_r <= 1'b0;
        end else if (done_s) begin
            hit_count  <= hit_count + {31'd0, hit};
            clr_pend_r <= last;
        end
    end
`endif

endmodule

// File: tb/tb_ray_sphere_hit.sv
// Directed, table-driven bench for ray_sphere_hit (define RAY_HIT_STATS_EN to
// also check the hit counter).
module tb_ray_sphere_hit;

    typedef struct {
        logic signed [11:0] dx, dy, dz;
        logic signed [11:0] px, py, pz;
        logic signed [11:0] cx, cy, cz;
        logic [11:0]        r;
        logic [31:0]        tag;
        logic               exp_hit;
        logic [7:0]         exp_shade;
        logic               exp_last;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [11:0] ray_dir_x = '0, ray_dir_y = '0, ray_dir_z = '0;
    logic [31:0] pixel_index = 32'd0;
    logic signed [11:0] camera_pos_x = '0, camera_pos_y = '0, camera_pos_z = '0;
    logic signed [11:0] sphere_cx = '0, sphere_cy = '0, sphere_cz = '0;
    logic [11:0] sphere_r = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic hit;
    logic [7:0] shade;
    logic [31:0] pixel_index_out;
    logic last;
`ifdef RAY_HIT_STATS_EN
    logic [31:0] hit_count;
`endif

    int n_pass = 0;
    int n_total = 0;
    int model_count = 0;
    vec_t vecs[9];

    always #5 clk = ~clk;

    ray_sphere_hit dut (
        .clk(clk), .reset_n(reset_n), .en(en),
        .in_valid(in_valid), .in_ready(in_ready),
        .ray_dir_x(ray_dir_x), .ray_dir_y(ray_dir_y), .ray_dir_z(ray_dir_z),
        .pixel_index(pixel_index),
        .camera_pos_x(camera_pos_x), .camera_pos_y(camera_pos_y), .camera_pos_z(camera_pos_z),
        .sphere_cx(sphere_cx), .sphere_cy(sphere_cy), .sphere_cz(sphere_cz),
        .sphere_r(sphere_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .hit(hit), .shade(shade), .pixel_index_out(pixel_index_out), .last(last)
`ifdef RAY_HIT_STATS_EN
        , .hit_count(hit_count)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic vec_t mk(input int dx, dy, dz, px, py, pz, cx, cy, cz, r,
                                input int tag, input bit h, input bit l);
        vec_t v;
        v.dx = 12'(dx); v.dy = 12'(dy); v.dz = 12'(dz);
        v.px = 12'(px); v.py = 12'(py); v.pz = 12'(pz);
        v.cx = 12'(cx); v.cy = 12'(cy); v.cz = 12'(cz);
        v.r = 12'(r); v.tag = 32'(tag);
        v.exp_hit = h; v.exp_shade = h ? 8'hFF : 8'h00; v.exp_last = l;
        return v;
    endfunction

    // One full transaction with optional backpressure and en dropped mid-ray.
    task automatic run_ray(input vec_t v, input int bp, input bit drop_en);
        int cyc;
        @(negedge clk);
        ray_dir_x = v.dx; ray_dir_y = v.dy; ray_dir_z = v.dz;
        camera_pos_x = v.px; camera_pos_y = v.py; camera_pos_z = v.pz;
        sphere_cx = v.cx; sphere_cy = v.cy; sphere_cz = v.cz;
        sphere_r = v.r; pixel_index = v.tag; in_valid = 1'b1;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        ray_dir_x = 12'($urandom); ray_dir_y = 12'($urandom); ray_dir_z = 12'($urandom);
        camera_pos_x = 12'($urandom); sphere_cz = 12'($urandom); sphere_r = 12'($urandom);
        pixel_index = $urandom;
        if (drop_en) en = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 64'(cyc), 64'd4);
        check("hit", 64'(hit), 64'(v.exp_hit));
        check("shade", 64'(shade), 64'(v.exp_shade));
        check("pixel_index_out", 64'(pixel_index_out), 64'(v.tag));
        check("last", 64'(last), 64'(v.exp_last));
        check("in_ready_busy", 64'(in_ready), 64'd0);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("hold", {out_valid, hit, shade, pixel_index_out, last, in_ready},
                  {1'b1, v.exp_hit, v.exp_shade, v.tag, v.exp_last, 1'b0});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_hs", 64'(out_valid), 64'd0);
        check("in_ready_after_hs", 64'(in_ready), 64'(!drop_en));
        en = 1'b1;
        if (v.exp_hit) model_count++;
`ifdef RAY_HIT_STATS_EN
        check("hit_count", 64'(hit_count), 64'(model_count));
`endif
        if (v.exp_last) begin
            model_count = 0;
            @(negedge clk);
`ifdef RAY_HIT_STATS_EN
            check("hit_count_clear", 64'(hit_count), 64'd0);
`endif
        end
    endtask

    initial begin
        bit seen;
        vecs[0] = mk(0, 0, 1, 0, 0, 0, 0, 0, 100, 10, 0, 1'b1, 1'b0);
        vecs[1] = mk(0, 0, -1, 0, 0, 0, 0, 0, 100, 10, 1, 1'b0, 1'b0);
        vecs[2] = mk(1, 0, 0, 0, 0, 0, 0, 0, 100, 10, 2, 1'b0, 1'b0);
        vecs[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 100, 10, 5, 1'b0, 1'b0);
        vecs[4] = mk(0, 0, 2, 5, 5, 0, 5, 5, 50, 3, 7, 1'b1, 1'b0);
        vecs[5] = mk(0, 0, 1, 0, 0, 0, 10, 0, 100, 10, 8, 1'b1, 1'b0);
        vecs[6] = mk(-2048, -2048, -2048, -2048, -2048, -2048, 2047, 2047, 2047, 4095, 9, 1'b0, 1'b0);
        vecs[7] = mk(2047, 2047, 2047, -2048, -2048, -2048, 2047, 2047, 2047, 4095, 10, 1'b1, 1'b0);
        vecs[8] = mk(0, 0, 1, 0, 0, 0, 0, 0, 100, 10, 65535, 1'b1, 1'b1);

        #12;
        check("rst_outputs", {out_valid, hit, shade, pixel_index_out, last},
              {1'b0, 1'b0, 8'h00, 32'd0, 1'b0});
`ifdef RAY_HIT_STATS_EN
        check("rst_hit_count", 64'(hit_count), 64'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) run_ray(vecs[i], 0, 1'b0);

        // Backpressure for 10 cycles, then en dropped mid-ray.
        run_ray(vecs[0], 10, 1'b0);
        run_ray(vecs[1], 2, 1'b1);

        @(negedge clk);
        en = 1'b0;
        #1 check("in_ready_en_low", 64'(in_ready), 64'd0);
        en = 1'b1;

        // Reset pulsed while the ray sits in DISC.
        @(negedge clk);
        ray_dir_x = 12'sd0; ray_dir_y = 12'sd0; ray_dir_z = 12'sd1;
        camera_pos_x = 12'sd0; camera_pos_y = 12'sd0; camera_pos_z = 12'sd0;
        sphere_cx = 12'sd0; sphere_cy = 12'sd0; sphere_cz = 12'sd100;
        sphere_r = 12'd10; pixel_index = 32'd42; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1 check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        model_count = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check("in_ready_after_rst", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no_output_after_rst", 64'(seen), 64'd0);

        // Frame end: three hits then the last pixel.
        run_ray(mk(0, 0, 1, 0, 0, 0, 0, 0, 100, 10, 100, 1'b1, 1'b0), 0, 1'b0);
        run_ray(mk(0, 0, 1, 0, 0, 0, 0, 0, 100, 10, 101, 1'b1, 1'b0), 0, 1'b0);
        run_ray(mk(0, 0, 1, 0, 0, 0, 0, 0, 100, 10, 102, 1'b1, 1'b0), 0, 1'b0);
        run_ray(mk(0, 0, -1, 0, 0, 0, 0, 0, 100, 10, 65535, 1'b0, 1'b1), 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/ray_sphere_hit.md
RAY_SPHERE_HIT -- requirements
Module: ray_sphere_hit

Interface
REQ-001 SHALL have parameter COORD_W, default 12, signed coordinate width.
REQ-002 SHALL have parameter NUM_PIXELS, default 65536, pixels per frame.
REQ-003 SHALL have parameter HIT_SHADE, default 8'hFF, shade emitted on hit.
REQ-004 SHALL have parameter BG_SHADE, default 8'h00, shade emitted on miss.
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk, input, 1, rising-edge clock; reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have en, input, 1, allows rays to be accepted.
REQ-007 SHALL have in_valid, input, 1, and in_ready, output, 1, as the ray handshake.
REQ-008 SHALL have ray_dir_x/y/z, input, COORD_W signed, ray direction; pixel_index, input, 32, pixel tag.
REQ-009 SHALL have camera_pos_x/y/z, input, COORD_W signed, ray origin.
REQ-010 SHALL have sphere_cx/cy/cz, input, COORD_W signed, and sphere_r, input, COORD_W unsigned, as the sphere.
REQ-011 SHALL have out_valid, output, 1, and out_ready, input, 1, as the result handshake.
REQ-012 SHALL have hit, output, 1; shade, output, 8; pixel_index_out, output, 32; last, output, 1.

Function
REQ-013 SHALL use FSM states IDLE, DOT, DISC, DECIDE and OUT.
REQ-014 SHALL drive in_ready=1 only in IDLE with en=1.
REQ-015 SHALL, in IDLE, capture the ray, origin, sphere and tag on in_valid&&in_ready, then go to DOT.
REQ-016 SHALL, in DOT, register a=d·d (26b), b=oc·d (27b signed) and c=oc·oc-r² (28b signed), with oc=origin-center computed at 13b; go to DISC.
REQ-017 SHALL, in DISC, register disc=b*b-a*c at 56b signed with no truncation; go to DECIDE.
REQ-018 SHALL, in DECIDE, set hit=(disc>=0)&&(b<0), shade=hit?HIT_SHADE:BG_SHADE, and last=(tag==NUM_PIXELS-1); go to OUT.
REQ-019 SHALL force hit=0 for an all-zero direction, regardless of disc.
REQ-020 SHALL assert out_valid only in OUT, with the first out_valid 4 cycles after the accept edge.
REQ-021 SHALL hold all outputs stable in OUT while out_ready=0.
REQ-022 SHALL return to IDLE on out_valid&&out_ready, with no bypass (in_ready=0 that cycle); maximum throughput is one ray per 5 cycles.
REQ-023 SHALL NOT abort an in-flight ray when en is deasserted mid-ray; en gates acceptance only.
REQ-024 SHALL ignore inputs outside the capture edge; captured values are used.

Reset
REQ-025 SHALL, on reset_n=0, asynchronously set state=IDLE, out_valid=0, hit=0, shade=0, last=0, pixel_index_out=0 and all datapath registers to 0.
REQ-026 SHALL discard any in-flight ray on reset mid-operation, produce no output for it, and allow in_ready after release.

Configuration
REQ-027 SHALL, when macro RAY_HIT_STATS_EN is defined, add output hit_count (32b), which increments on each handshaken result with hit=1, clears to 0 on the cycle after a handshaken result with last=1, and resets to 0.
REQ-028 SHALL, without RAY_HIT_STATS_EN, have neither the hit_count port nor the counter logic; other behaviour is identical.

Structure
REQ-029 SHALL place the state enum and width constants (A_W=26, B_W=27, C_W=28, DISC_W=56) in shared package ray_pkg.
REQ-030 SHALL implement the three dot products with one sub-module, dot3: a combinational signed 3-term dot product with parameterised widths, instantiated three times.

Verification
REQ-031 SHALL cover hit: origin (0,0,0), center (0,0,100), r=10, dir (0,0,1) -> a=1, b=-100, c=9900, disc=100, hit=1, shade=FF, out_valid at accept+4.
REQ-032 SHALL cover behind-camera and miss: same sphere, dir (0,0,-1) -> b=100, hit=0, shade=00; dir (1,0,0) -> disc=-9900, hit=0.
REQ-033 SHALL cover zero direction: dir (0,0,0), tag 5 -> hit=0, shade=BG_SHADE, pixel_index_out=5.
REQ-034 SHALL cover backpressure: out_ready=0 for 10 cycles after out_valid -> outputs constant, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-035 SHALL cover reset mid-ray: reset_n pulsed low in DISC -> out_valid=0 immediately, no result emitted, in_ready=1 after release with en=1.
REQ-036 SHALL cover frame end with stats: tag 65535 -> last=1; with RAY_HIT_STATS_EN, 3 hits then last -> hit_count=3, then 0 after the handshake.
